// File: rtl/pc_gen.sv
//------------------------------------------------------------------------------
// pc_gen : fetch PC generator with exception / ID redirect and delay-slot wait
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_gen #(
  parameter int          FETCH_WIDTH = 2,
  parameter logic [31:0] RESET_PC    = 32'hBFC0_0000,
  parameter int          CNT_W       = $clog2(FETCH_WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [CNT_W-1:0] inst_ok_cnt,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_target,
  input  logic             id_take_j_imme,
  input  logic [25:0]      id_j_imme,
  input  logic             id_take_branch,
  input  logic [15:0]      id_branch_offset,
  input  logic             id_take_jr,
  input  logic [31:0]      id_rs_data,
  input  logic [31:0]      id_pc,
  input  logic             id_ds_fetched,
  output logic [31:0]      fetch_pc,
  output logic             fetch_valid,
  output logic             redirect_flush,
  output logic             ds_wait
);

  localparam logic [31:0] c_fetch_w = 32'(FETCH_WIDTH);

  typedef enum logic [0:0] {
    S_RUN     = 1'b0,
    S_DS_WAIT = 1'b1
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_pend, w_pend_nxt;
  logic        r_flush, w_flush_nxt;

  logic [31:0] w_cnt_ext;
  logic [31:0] w_cnt_clamped;
  logic [31:0] w_seq_pc;
  logic [31:0] w_br_target;
  logic [31:0] w_id_target;
  logic        w_id_redirect;

  assign w_cnt_ext     = 32'(inst_ok_cnt);
  assign w_cnt_clamped = (w_cnt_ext > c_fetch_w) ? c_fetch_w : w_cnt_ext;
  assign w_seq_pc      = r_pc + (w_cnt_clamped << 2);

  assign w_br_target   = id_pc + 32'd4 + {{14{id_branch_offset[15]}}, id_branch_offset, 2'b00};
  assign w_id_redirect = (id_take_j_imme | id_take_branch | id_take_jr) & ~stall;

  always_comb begin
    w_id_target = id_rs_data;
    if (id_take_j_imme)      w_id_target = {id_pc[31:28], id_j_imme, 2'b00};
    else if (id_take_branch) w_id_target = w_br_target;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_pend_nxt  = r_pend;
    w_flush_nxt = 1'b0;
    if (ex_redirect) begin
      w_pc_nxt    = ex_target;
      w_pend_nxt  = 32'd0;
      w_state_nxt = S_RUN;
      w_flush_nxt = 1'b1;
    end else begin
      case (r_state)
        S_DS_WAIT: begin
          // Delay slot has arrived; anything fetched beyond it is discarded by the flush.
          if (!stall && (inst_ok_cnt != '0)) begin
            w_pc_nxt    = r_pend;
            w_state_nxt = S_RUN;
            w_flush_nxt = 1'b1;
          end
        end
        default: begin
          if (w_id_redirect) begin
            if (id_ds_fetched) begin
              w_pc_nxt    = w_id_target;
              w_flush_nxt = 1'b1;
            end else begin
              w_pend_nxt  = w_id_target;
              w_state_nxt = S_DS_WAIT;
              w_pc_nxt    = w_seq_pc;
            end
          end else if (!stall) begin
            w_pc_nxt = w_seq_pc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
      r_pc    <= RESET_PC;
      r_pend  <= 32'd0;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_pend  <= w_pend_nxt;
      r_flush <= w_flush_nxt;
    end
  end

  assign fetch_pc       = r_pc;
  assign fetch_valid    = ~rst;
  assign redirect_flush = r_flush;
  assign ds_wait        = (r_state == S_DS_WAIT);

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
//------------------------------------------------------------------------------
// tb_pc_gen : scoreboard bench for pc_gen (directed scenarios + random traffic)
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_gen;

  localparam int          FW    = 2;
  localparam logic [31:0] RPC   = 32'hBFC0_0000;
  localparam int          CW    = $clog2(FW + 1);

  logic          clk;
  logic          rst;
  logic          stall;
  logic [CW-1:0] inst_ok_cnt;
  logic          ex_redirect;
  logic [31:0]   ex_target;
  logic          id_take_j_imme;
  logic [25:0]   id_j_imme;
  logic          id_take_branch;
  logic [15:0]   id_branch_offset;
  logic          id_take_jr;
  logic [31:0]   id_rs_data;
  logic [31:0]   id_pc;
  logic          id_ds_fetched;
  logic [31:0]   fetch_pc;
  logic          fetch_valid;
  logic          redirect_flush;
  logic          ds_wait;

  pc_gen #(.FETCH_WIDTH(FW), .RESET_PC(RPC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .inst_ok_cnt(inst_ok_cnt),
    .ex_redirect(ex_redirect), .ex_target(ex_target),
    .id_take_j_imme(id_take_j_imme), .id_j_imme(id_j_imme),
    .id_take_branch(id_take_branch), .id_branch_offset(id_branch_offset),
    .id_take_jr(id_take_jr), .id_rs_data(id_rs_data), .id_pc(id_pc),
    .id_ds_fetched(id_ds_fetched), .fetch_pc(fetch_pc),
    .fetch_valid(fetch_valid), .redirect_flush(redirect_flush), .ds_wait(ds_wait)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] pc;
    logic        flush;
    logic        dsw;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: what the fetch unit should be doing, in architectural terms.
  logic [31:0] m_pc;
  logic        m_waiting;
  logic [31:0] m_pending;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_pc      = RPC;
    m_waiting = 1'b0;
    m_pending = 32'd0;
  endtask

  task automatic idle();
    stall = 0; inst_ok_cnt = '0; ex_redirect = 0; ex_target = '0;
    id_take_j_imme = 0; id_j_imme = '0; id_take_branch = 0; id_branch_offset = '0;
    id_take_jr = 0; id_rs_data = '0; id_pc = '0; id_ds_fetched = 0;
  endtask

  task automatic nxt();
    @(negedge clk);
    idle();
  endtask

  // Predict the outcome of the coming edge from the inputs now applied.
  task automatic fire();
    exp_t        e;
    logic [31:0] target;
    logic [31:0] sext_off;
    int unsigned n;
    bit          id_req;
    n        = (int'(inst_ok_cnt) > FW) ? FW : int'(inst_ok_cnt);
    sext_off = {{16{id_branch_offset[15]}}, id_branch_offset};
    if (id_take_j_imme)      target = {id_pc[31:28], id_j_imme, 2'b00};
    else if (id_take_branch) target = id_pc + 32'd4 + sext_off * 32'd4;
    else                     target = id_rs_data;
    id_req  = (id_take_j_imme || id_take_branch || id_take_jr) && !stall;
    e.flush = 1'b0;
    if (ex_redirect) begin
      m_pc = ex_target; m_waiting = 1'b0; m_pending = 32'd0; e.flush = 1'b1;
    end else if (m_waiting) begin
      if (!stall && n > 0) begin
        m_pc = m_pending; m_waiting = 1'b0; e.flush = 1'b1;
      end
    end else if (id_req && id_ds_fetched) begin
      m_pc = target; e.flush = 1'b1;
    end else if (id_req) begin
      m_pending = target; m_waiting = 1'b1; m_pc = m_pc + 32'(4 * n);
    end else if (!stall) begin
      m_pc = m_pc + 32'(4 * n);
    end
    e.pc  = m_pc;
    e.dsw = m_waiting;
    q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compares each registered response against the oldest prediction.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (fetch_valid && q.size() > 0) begin
      e = q.pop_front();
      check("fetch_pc", fetch_pc, e.pc);
      check("redirect_flush", 32'(redirect_flush), 32'(e.flush));
      check("ds_wait", 32'(ds_wait), 32'(e.dsw));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst = 1'b1;
    model_reset();
    #1;
    check("reset_pc", fetch_pc, RPC);
    check("reset_valid", 32'(fetch_valid), 32'd0);
    check("reset_flush", 32'(redirect_flush), 32'd0);
    check("reset_dsw", 32'(ds_wait), 32'd0);

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("valid_after_release", 32'(fetch_valid), 32'd1);

    // Sequential advance
    for (int i = 0; i < 3; i++) begin
      nxt(); inst_ok_cnt = 2; fire();
    end
    settle();
    check("seq_x3", fetch_pc, 32'hBFC0_0018);
    nxt(); inst_ok_cnt = 1; fire();
    settle();
    check("seq_plus4", fetch_pc, 32'hBFC0_001C);

    // Backward branch with delay slot already fetched
    nxt(); id_pc = 32'h8000_1000; id_take_branch = 1; id_branch_offset = 16'hFFFF;
    id_ds_fetched = 1; inst_ok_cnt = 2; fire();
    settle();
    check("branch_target", fetch_pc, 32'h8000_1000);
    check("branch_flush", 32'(redirect_flush), 32'd1);
    nxt(); fire();
    settle();
    check("flush_one_cycle", 32'(redirect_flush), 32'd0);

    // Jump whose delay slot is still outstanding
    nxt(); inst_ok_cnt = 1; fire();
    nxt(); id_pc = 32'h8000_1000; id_take_j_imme = 1; id_j_imme = 26'h012_3456;
    id_ds_fetched = 0; inst_ok_cnt = 1; fire();
    nxt(); inst_ok_cnt = 0; fire();
    nxt(); inst_ok_cnt = 0; id_take_jr = 1; id_rs_data = 32'h1111_1110; fire();
    settle();
    check("ds_wait_held", 32'(ds_wait), 32'd1);
    check("ds_wait_pc", fetch_pc, 32'h8000_1008);
    nxt(); inst_ok_cnt = 1; fire();
    settle();
    check("jump_target", fetch_pc, 32'h8048_D158);
    check("jump_dsw_clear", 32'(ds_wait), 32'd0);

    // Exception wins over delay-slot completion
    nxt(); id_pc = 32'h8048_D150; id_take_branch = 1; id_branch_offset = 16'h0040;
    inst_ok_cnt = 1; fire();
    nxt(); ex_redirect = 1; ex_target = 32'hBFC0_0380; inst_ok_cnt = 1; fire();
    nxt(); inst_ok_cnt = 1; fire();
    settle();
    check("ex_over_ds", fetch_pc, 32'hBFC0_0384);

    // Stall masks ID redirect; wrap past 2^32
    nxt(); stall = 1; id_take_jr = 1; id_rs_data = 32'h1234_5678; inst_ok_cnt = 2; fire();
    settle();
    check("stall_hold", fetch_pc, 32'hBFC0_0384);
    nxt(); ex_redirect = 1; ex_target = 32'hFFFF_FFFC; fire();
    nxt(); inst_ok_cnt = 2; fire();
    settle();
    check("wrap", fetch_pc, 32'h0000_0004);

    // Asynchronous reset in the middle of DS_WAIT
    nxt(); id_pc = 32'h0000_0100; id_take_branch = 1; id_branch_offset = 16'h0010; fire();
    settle();
    rst = 1'b1;
    #1;
    check("async_rst_pc", fetch_pc, RPC);
    check("async_rst_dsw", 32'(ds_wait), 32'd0);
    check("async_rst_valid", 32'(fetch_valid), 32'd0);
    @(negedge clk);
    idle();
    rst = 1'b0;
    model_reset();
    fire();
    settle();
    check("post_rst_hold", fetch_pc, RPC);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      nxt();
      stall            = ($urandom_range(0, 3) == 0);
      inst_ok_cnt      = CW'($urandom_range(0, FW));
      ex_redirect      = ($urandom_range(0, 19) == 0);
      ex_target        = $urandom();
      id_take_j_imme   = ($urandom_range(0, 5) == 0);
      id_j_imme        = 26'($urandom());
      id_take_branch   = ($urandom_range(0, 4) == 0);
      id_branch_offset = 16'($urandom());
      id_take_jr       = ($urandom_range(0, 4) == 0);
      id_rs_data       = $urandom();
      id_pc            = $urandom();
      id_ds_fetched    = $urandom_range(0, 1) == 1;
      fire();
    end

    nxt();
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
